// File: rtl/voq_request_gen.sv
// VOQ occupancy tracking, request map and transfer timers for a p-iSLIP scheduler.
// Optional grant protocol checking is enabled with `define GRANT_CHECK_EN.
module voq_request_gen #(
  parameter int unsigned N       = 12,
  parameter int unsigned P       = 8,
  parameter int unsigned LOGN    = 4,
  parameter int unsigned LOGP    = 3,
  parameter int unsigned CNTW    = 8,
  parameter int unsigned XFER    = 4,
  parameter int unsigned LOGXFER = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_arr_valid,
  input  logic [LOGN-1:0]     i_arr_input,
  input  logic [LOGN-1:0]     i_arr_output,
  input  logic [LOGP-1:0]     i_arr_pri,
  input  logic [N*N-1:0]      i_acc_grant,
  input  logic [N*P-1:0]      i_acc_priority,
  output logic [N*N*P-1:0]    o_priority,
  output logic [N-1:0]        o_input_idle,
  output logic [N-1:0]        o_output_idle,
  output logic [N*N-1:0]      o_xbar_config,
  output logic                o_overflow,
  output logic                o_grant_err
);

  localparam logic [CNTW-1:0] CntMax = '1;

  logic [CNTW-1:0]    cnt_q [N][N][P];
  logic [CNTW-1:0]    cnt_d [N][N][P];
  logic [LOGXFER-1:0] tin_q [N];
  logic [LOGXFER-1:0] tin_d [N];
  logic [LOGXFER-1:0] tout_q [N];
  logic [LOGXFER-1:0] tout_d [N];
  logic [N*N-1:0]     xbar_q, xbar_d, gnt_app;
  logic [N*N*P-1:0]   prio_q, prio_d;
  logic               ovf_q, ovf_d;
  logic [P-1:0]       pone [N];
  logic [N-1:0]       row_hit, col_hit;
  logic               arr_ok, inc, dec;

  assign arr_ok = i_arr_valid && (32'(i_arr_input) < N) && (32'(i_arr_output) < N) &&
                  (32'(i_arr_pri) < P);

  // Lowest set bit of each input's priority field selects the VOQ to dequeue.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      pone[i] = i_acc_priority[i*P +: P] & (~i_acc_priority[i*P +: P] + P'(1));
    end
  end

`ifdef GRANT_CHECK_EN
  logic [N-1:0] gcol [N];
  logic [P-1:0] nz [N][N];
  logic         err_q, err_d;

  always_comb begin
    for (int j = 0; j < N; j++) begin
      gcol[j] = '0;
      for (int i = 0; i < N; i++) begin
        gcol[j][i] = i_acc_grant[i*N+j];
        for (int k = 0; k < P; k++) nz[i][j][k] = (cnt_q[i][j][k] != '0);
      end
    end
  end

  // A violating entry is dropped entirely: no dequeue and no timer load.
  always_comb begin
    gnt_app = '0;
    err_d   = err_q;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i_acc_grant[i*N+j]) begin
          if (!$onehot(i_acc_grant[i*N +: N]) || !$onehot(gcol[j]) ||
              !$onehot(i_acc_priority[i*P +: P]) || (tin_q[i] != '0) ||
              (tout_q[j] != '0) || ((pone[i] & nz[i][j]) == '0)) begin
            err_d = 1'b1;
          end else begin
            gnt_app[i*N+j] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign o_grant_err = err_q;
`else
  assign gnt_app     = i_acc_grant;
  assign o_grant_err = 1'b0;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    prio_d  = '0;
    row_hit = '0;
    col_hit = '0;
    xbar_d  = '0;
    inc     = 1'b0;
    dec     = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        row_hit[i] = row_hit[i] | gnt_app[i*N+j];
        col_hit[j] = col_hit[j] | gnt_app[i*N+j];
        for (int k = 0; k < P; k++) begin
          inc = arr_ok && (i_arr_input == LOGN'(i)) && (i_arr_output == LOGN'(j)) &&
                (i_arr_pri == LOGP'(k));
          dec = gnt_app[i*N+j] && pone[i][k];
          if (inc && !dec) begin
            if (cnt_q[i][j][k] == CntMax) ovf_d = 1'b1;
            else                          cnt_d[i][j][k] = cnt_q[i][j][k] + CNTW'(1);
          end else if (dec && !inc && (cnt_q[i][j][k] != '0)) begin
            cnt_d[i][j][k] = cnt_q[i][j][k] - CNTW'(1);
          end
          prio_d[i*N*P + k*N + j] = (cnt_q[i][j][k] != '0);
        end
      end
    end
    // A crosspoint survives until its input timer expires or either port is regranted.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        xbar_d[i*N+j] = gnt_app[i*N+j] |
                        (xbar_q[i*N+j] & ~row_hit[i] & ~col_hit[j] &
                         (tin_q[i] > LOGXFER'(1)));
      end
    end
    for (int i = 0; i < N; i++) begin
      tin_d[i]  = row_hit[i] ? LOGXFER'(XFER) :
                  ((tin_q[i] != '0) ? tin_q[i] - LOGXFER'(1) : '0);
      tout_d[i] = col_hit[i] ? LOGXFER'(XFER) :
                  ((tout_q[i] != '0) ? tout_q[i] - LOGXFER'(1) : '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        tin_q[i]  <= '0;
        tout_q[i] <= '0;
        for (int j = 0; j < N; j++) begin
          for (int k = 0; k < P; k++) cnt_q[i][j][k] <= '0;
        end
      end
      xbar_q <= '0;
      prio_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tin_q  <= tin_d;
      tout_q <= tout_d;
      xbar_q <= xbar_d;
      prio_q <= prio_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      o_input_idle[i]  = (tin_q[i] == '0);
      o_output_idle[i] = (tout_q[i] == '0);
    end
  end

  assign o_priority    = prio_q;
  assign o_xbar_config = xbar_q;
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_voq_request_gen.sv
// Directed bench for voq_request_gen with N=4, P=2, CNTW=2, XFER=3.
module tb_voq_request_gen;
  localparam int unsigned N = 4, P = 2, LOGN = 3, LOGP = 2, CNTW = 2, XFER = 3, LOGXFER = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             arr_valid;
  logic [LOGN-1:0]  arr_input, arr_output;
  logic [LOGP-1:0]  arr_pri;
  logic [N*N-1:0]   acc_grant;
  logic [N*P-1:0]   acc_pri;
  logic [N*N*P-1:0] prio;
  logic [N-1:0]     in_idle, out_idle;
  logic [N*N-1:0]   xbar;
  logic             ovf, gerr;
  int               tests = 0;
  int               fails = 0;

  voq_request_gen #(
    .N(N), .P(P), .LOGN(LOGN), .LOGP(LOGP), .CNTW(CNTW), .XFER(XFER), .LOGXFER(LOGXFER)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_arr_valid   (arr_valid),
    .i_arr_input   (arr_input),
    .i_arr_output  (arr_output),
    .i_arr_pri     (arr_pri),
    .i_acc_grant   (acc_grant),
    .i_acc_priority(acc_pri),
    .o_priority    (prio),
    .o_input_idle  (in_idle),
    .o_output_idle (out_idle),
    .o_xbar_config (xbar),
    .o_overflow    (ovf),
    .o_grant_err   (gerr)
  );

  always #5 clk = ~clk;

`ifdef GRANT_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    arr_valid = 1'b0; arr_input = '0; arr_output = '0; arr_pri = '0;
    acc_grant = '0;   acc_pri = '0;
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic arrive(input int i, input int o, input int p);
    arr_valid = 1'b1; arr_input = LOGN'(i); arr_output = LOGN'(o); arr_pri = LOGP'(p);
  endtask

  task automatic grant(input logic [N*N-1:0] g, input logic [N*P-1:0] p);
    acc_grant = g; acc_pri = p;
  endtask

  task automatic test_reset();
    clr();
    reset = 1'b0;
    tick();
    tests++; if (in_idle !== 4'hF) begin fails++; $display("FAIL rst_in_idle: got %h want f", in_idle); end
    tests++; if (out_idle !== 4'hF) begin fails++; $display("FAIL rst_out_idle: got %h want f", out_idle); end
    tests++; if (prio !== 32'h0) begin fails++; $display("FAIL rst_prio: got %h want 0", prio); end
    tests++; if (xbar !== 16'h0) begin fails++; $display("FAIL rst_xbar: got %h want 0", xbar); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    tests++; if (gerr !== 1'b0) begin fails++; $display("FAIL rst_gerr: got %b want 0", gerr); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_arrival();
    do_reset();
    arrive(1, 2, 1);
    tick();
    clr();
    tests++; if (prio !== 32'h0) begin fails++; $display("FAIL arr_t1: got %h want 0", prio); end
    tick();
    tests++; if (prio !== 32'h0000_4000) begin fails++; $display("FAIL arr_t2: got %h want 4000", prio); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL arr_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    do_reset();
    arrive(1, 2, 1);
    repeat (4) tick();
    clr();
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    for (int g = 0; g < 3; g++) begin
      grant(16'h0040, 8'h08);
      tick();
      clr();
      repeat (3) tick();
      exp = (g < 2) ? 32'h0000_4000 : 32'h0;
      tests++; if (prio !== exp) begin fails++; $display("FAIL ovf_drain%0d: got %h want %h", g, prio, exp); end
    end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    grant(16'h0040, 8'h08);
    tick();
    clr();
    repeat (3) tick();
    tests++; if (prio !== 32'h0) begin fails++; $display("FAIL sat_zero: got %h want 0", prio); end
    tests++; if (gerr !== ChkEn) begin fails++; $display("FAIL sat_gerr: got %b want %b", gerr, ChkEn); end
  endtask

  task automatic test_xfer();
    do_reset();
    arrive(1, 2, 1);
    tick();
    clr();
    tick();
    grant(16'h0040, 8'h08);
    tick();
    clr();
    for (int c = 1; c <= 3; c++) begin
      tests++; if (in_idle !== 4'b1101) begin fails++; $display("FAIL xfer_in_t%0d: got %h want d", c, in_idle); end
      tests++; if (out_idle !== 4'b1011) begin fails++; $display("FAIL xfer_out_t%0d: got %h want b", c, out_idle); end
      tests++; if (xbar !== 16'h0040) begin fails++; $display("FAIL xfer_xbar_t%0d: got %h want 0040", c, xbar); end
      tick();
    end
    tests++; if (in_idle !== 4'hF) begin fails++; $display("FAIL xfer_in_end: got %h want f", in_idle); end
    tests++; if (out_idle !== 4'hF) begin fails++; $display("FAIL xfer_out_end: got %h want f", out_idle); end
    tests++; if (xbar !== 16'h0) begin fails++; $display("FAIL xfer_xbar_end: got %h want 0", xbar); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    arrive(1, 2, 1);
    tick();
    clr();
    tick();
    arrive(1, 2, 1);
    grant(16'h0040, 8'h08);
    tick();
    clr();
    repeat (3) tick();
    tests++; if (prio !== 32'h0000_4000) begin fails++; $display("FAIL same_prio: got %h want 4000", prio); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL same_ovf: got %b want 0", ovf); end
    tests++; if (gerr !== 1'b0) begin fails++; $display("FAIL same_gerr: got %b want 0", gerr); end
    grant(16'h0040, 8'h08);
    tick();
    clr();
    repeat (3) tick();
    tests++; if (prio !== 32'h0) begin fails++; $display("FAIL same_drain: got %h want 0", prio); end
  endtask

  task automatic test_busy_grant();
    logic [3:0]  exp_out;
    logic [31:0] exp_prio;
    do_reset();
    arrive(1, 2, 1);
    tick();
    tick();
    clr();
    tick();
    grant(16'h0040, 8'h08);
    tick();
    clr();
    tick();
    grant(16'h0040, 8'h08);
    tick();
    clr();
    tests++; if (gerr !== ChkEn) begin fails++; $display("FAIL busy_gerr: got %b want %b", gerr, ChkEn); end
    exp_out = ChkEn ? 4'hF : 4'b1011;
    for (int c = 4; c <= 5; c++) begin
      tick();
      tests++; if (out_idle !== exp_out) begin fails++; $display("FAIL busy_out_t%0d: got %h want %h", c, out_idle, exp_out); end
    end
    tick();
    exp_prio = ChkEn ? 32'h0000_4000 : 32'h0;
    tests++; if (out_idle !== 4'hF) begin fails++; $display("FAIL busy_out_t6: got %h want f", out_idle); end
    tests++; if (prio !== exp_prio) begin fails++; $display("FAIL busy_prio: got %h want %h", prio, exp_prio); end
  endtask

  task automatic test_multi();
    do_reset();
    arrive(0, 3, 0);
    tick();
    arrive(3, 0, 1);
    tick();
    clr();
    tick();
    tests++; if (prio !== 32'h1000_0008) begin fails++; $display("FAIL multi_prio: got %h want 10000008", prio); end
    grant(16'h1008, 8'h81);
    tick();
    clr();
    tests++; if (in_idle !== 4'b0110) begin fails++; $display("FAIL multi_in: got %h want 6", in_idle); end
    tests++; if (out_idle !== 4'b0110) begin fails++; $display("FAIL multi_out: got %h want 6", out_idle); end
    tests++; if (xbar !== 16'h1008) begin fails++; $display("FAIL multi_xbar: got %h want 1008", xbar); end
    tick();
    tests++; if (prio !== 32'h0) begin fails++; $display("FAIL multi_drain: got %h want 0", prio); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    arrive(4, 0, 0);
    tick();
    arrive(0, 5, 0);
    tick();
    arrive(0, 0, 2);
    tick();
    clr();
    tick();
    tick();
    tests++; if (prio !== 32'h0) begin fails++; $display("FAIL oor_prio: got %h want 0", prio); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL oor_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    arrive(2, 1, 0);
    tick();
    clr();
    tick();
    grant(16'h0200, 8'h10);
    tick();
    clr();
    tests++; if (xbar !== 16'h0200) begin fails++; $display("FAIL mid_xbar_pre: got %h want 0200", xbar); end
    #2;
    reset = 1'b0;
    #1;
    tests++; if (xbar !== 16'h0) begin fails++; $display("FAIL mid_xbar: got %h want 0", xbar); end
    tests++; if (in_idle !== 4'hF) begin fails++; $display("FAIL mid_in: got %h want f", in_idle); end
    tests++; if (out_idle !== 4'hF) begin fails++; $display("FAIL mid_out: got %h want f", out_idle); end
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_arrival();
    test_overflow();
    test_xfer();
    test_same_cycle();
    test_busy_grant();
    test_multi();
    test_out_of_range();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
